// File: rtl/matrix_stream_serializer_if.sv
// Stream bundle around the matrix serializer: one wide matrix beat in, one element per beat out.
interface matrix_stream_serializer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 4
);
    localparam int unsigned IDX_W   = $clog2(SIZE);
    localparam int unsigned FRAME_W = WIDTH * SIZE * SIZE;

    logic [FRAME_W-1:0]   s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [WIDTH-1:0]     m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [2*IDX_W-1:0]   m_axis_tuser;

    // Serializer side: consumes the matrix stream, drives the element stream.
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // Environment side: produces matrices, consumes elements.
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/matrix_stream_serializer.sv
// Accepts a flattened SIZE x SIZE matrix in one handshake and emits it one
// element per beat in row-major order, with {row, col} on tuser and tlast on
// the final element. A new matrix may be taken on the last beat (no bubble).
module matrix_stream_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    matrix_stream_serializer_if.master   axis,
    output logic                         busy
);
    localparam int unsigned N_ELEM = SIZE * SIZE;
    localparam int unsigned CNT_W  = $clog2(N_ELEM);
    localparam int unsigned IDX_W  = $clog2(SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   k_q;
    logic [IDX_W-1:0]   row_q;
    logic [IDX_W-1:0]   col_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   shadow_q [N_ELEM];
    logic [WIDTH-1:0]   in_elem_c [N_ELEM];

    logic               last_hs_c;
    logic               advance_c;
    logic               s_ready_c;
    logic               accept_c;
    logic               col_wrap_c;
    logic [CNT_W-1:0]   k_nxt_c;
    logic [IDX_W-1:0]   row_nxt_c;
    logic [IDX_W-1:0]   col_nxt_c;

    // Split the flattened input bus into row-major elements.
    for (genvar e = 0; e < N_ELEM; e++) begin : g_split
        assign in_elem_c[e] = axis.s_axis_tdata[e*WIDTH +: WIDTH];
    end

    // Handshake decode and next element index; ready opens on the last-beat handshake.
    always_comb begin
        last_hs_c  = (state == SEND) & last_q & axis.m_axis_tready;
        advance_c  = (state == SEND) & ~last_q & axis.m_axis_tready;
        s_ready_c  = (state == IDLE) | last_hs_c;
        accept_c   = axis.s_axis_tvalid & s_ready_c;
        k_nxt_c    = k_q + CNT_W'(1);
        col_wrap_c = (col_q == IDX_W'(SIZE - 1));
        col_nxt_c  = col_wrap_c ? '0 : col_q + IDX_W'(1);
        row_nxt_c  = col_wrap_c ? row_q + IDX_W'(1) : row_q;
    end

    // Control FSM: index counter, valid/last/busy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept_c) begin
            state   <= SEND;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else if (last_hs_c) begin
            state   <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (advance_c) begin
            k_q     <= k_nxt_c;
            row_q   <= row_nxt_c;
            col_q   <= col_nxt_c;
            last_q  <= (k_nxt_c == CNT_W'(N_ELEM - 1));
        end
    end

    // Data path: shadow matrix and outgoing element, intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            shadow_q <= in_elem_c;
            data_q   <= in_elem_c[0];
        end else if (advance_c) begin
            data_q   <= shadow_q[k_nxt_c];
        end
    end

    assign axis.s_axis_tready = s_ready_c;
    assign axis.m_axis_tdata  = data_q;
    assign axis.m_axis_tvalid = valid_q;
    assign axis.m_axis_tlast  = last_q;
    assign axis.m_axis_tuser  = {row_q, col_q};
    assign busy               = busy_q;
endmodule

// File: tb/tb_matrix_stream_serializer.sv
// Bench for matrix_stream_serializer: scoreboarded element streams for a
// 4x4/32-bit instance and a 2x2/16-bit instance.
module tb_matrix_stream_serializer;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic busy4, busy2;
    int   total = 0;
    int   passed = 0;
    int   beats4 = 0;
    int   beats2 = 0;
    beat_t q4[$];
    beat_t q2[$];
    beat_t e4, e2;

    matrix_stream_serializer_if #(.WIDTH(32), .SIZE(4)) if4 ();
    matrix_stream_serializer_if #(.WIDTH(16), .SIZE(2)) if2 ();

    matrix_stream_serializer #(.WIDTH(32), .SIZE(4)) dut4 (
        .clk(clk), .reset(reset), .axis(if4), .busy(busy4)
    );
    matrix_stream_serializer #(.WIDTH(16), .SIZE(2)) dut2 (
        .clk(clk), .reset(reset), .axis(if2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard for the 4x4 instance: every handshaked beat must match the next expected element.
    always @(negedge clk) begin
        if (!reset && if4.m_axis_tvalid && if4.m_axis_tready) begin
            beats4++;
            total++;
            if (q4.size() == 0) begin
                $display("FAIL beat4_unexpected: got data=%h user=%h last=%b, required no beat",
                         if4.m_axis_tdata, if4.m_axis_tuser, if4.m_axis_tlast);
            end else begin
                e4 = q4.pop_front();
                if (if4.m_axis_tdata !== e4.d || if4.m_axis_tuser !== e4.u || if4.m_axis_tlast !== e4.l)
                    $display("FAIL beat4: got data=%h user=%h last=%b, required data=%h user=%h last=%b",
                             if4.m_axis_tdata, if4.m_axis_tuser, if4.m_axis_tlast, e4.d, e4.u, e4.l);
                else
                    passed++;
            end
        end
    end

    // Scoreboard for the 2x2 instance.
    always @(negedge clk) begin
        if (!reset && if2.m_axis_tvalid && if2.m_axis_tready) begin
            beats2++;
            total++;
            if (q2.size() == 0) begin
                $display("FAIL beat2_unexpected: got data=%h user=%h last=%b, required no beat",
                         if2.m_axis_tdata, if2.m_axis_tuser, if2.m_axis_tlast);
            end else begin
                e2 = q2.pop_front();
                if (if2.m_axis_tdata !== e2.d[15:0] || if2.m_axis_tuser !== e2.u[1:0] || if2.m_axis_tlast !== e2.l)
                    $display("FAIL beat2: got data=%h user=%h last=%b, required data=%h user=%h last=%b",
                             if2.m_axis_tdata, if2.m_axis_tuser, if2.m_axis_tlast, e2.d[15:0], e2.u[1:0], e2.l);
                else
                    passed++;
            end
        end
    end

    function automatic logic [31:0] elem4(input int kind, input int i, input int j);
        case (kind)
            0:       return 32'(256 * i + j);
            1:       return 32'(i + j);
            2:       return 32'(32'h1000 + i + j);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a 4x4 frame onto the input bus and queue its expected beats.
    task automatic load4(input int kind);
        logic [511:0] f;
        logic [31:0]  v;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = elem4(kind, i, j);
                f = f | (512'(v) << ((i * 4 + j) * 32));
                q4.push_back('{d: v, u: 4'(i * 4 + j), l: (i == 3 && j == 3)});
            end
        end
        if4.s_axis_tdata = f;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b, required 0", if4.m_axis_tvalid); else passed++;
        total++; if (if4.m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b, required 0", if4.m_axis_tlast); else passed++;
        total++; if (if4.m_axis_tuser !== 4'h0) $display("FAIL rst_tuser: got %h, required 0", if4.m_axis_tuser); else passed++;
        total++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy4); else passed++;
        total++; if (if4.s_axis_tready !== 1'b1) $display("FAIL rst_sready: got %b, required 1", if4.s_axis_tready); else passed++;
        total++; if (if2.m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid2: got %b, required 0", if2.m_axis_tvalid); else passed++;
        tick;
        reset = 1'b0;
        @(negedge clk);
        total++; if (if4.s_axis_tready !== 1'b1) $display("FAIL rst_sready_after: got %b, required 1", if4.s_axis_tready); else passed++;
    endtask

    task automatic test_single;
        int b0;
        tick;
        if4.m_axis_tready = 1'b1;
        load4(0);
        if4.s_axis_tvalid = 1'b1;
        b0 = beats4;
        @(negedge clk);
        total++; if (if4.s_axis_tready !== 1'b1) $display("FAIL single_sready: got %b, required 1", if4.s_axis_tready); else passed++;
        tick;
        if4.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            total++;
            if ({if4.m_axis_tvalid, busy4} !== 2'b11)
                $display("FAIL single_valid_c%0d: got valid=%b busy=%b, required 1 1", c, if4.m_axis_tvalid, busy4);
            else passed++;
        end
        @(negedge clk);
        total++; if ({if4.m_axis_tvalid, busy4} !== 2'b00) $display("FAIL single_idle: got valid=%b busy=%b, required 0 0", if4.m_axis_tvalid, busy4); else passed++;
        total++; if (beats4 - b0 !== 16) $display("FAIL single_beats: got %0d, required 16", beats4 - b0); else passed++;
    endtask

    task automatic test_backpressure;
        int b0;
        tick;
        load4(0);
        if4.s_axis_tvalid = 1'b1;
        b0 = beats4;
        @(negedge clk);
        tick;
        if4.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if4.m_axis_tready = !(c inside {2, 3, 4, 18});
            @(negedge clk);
            if (c inside {2, 3, 4}) begin
                total++;
                if (if4.m_axis_tvalid !== 1'b1 || if4.m_axis_tdata !== 32'h0000_0002 || if4.m_axis_tuser !== 4'h2)
                    $display("FAIL bp_hold_c%0d: got valid=%b data=%h user=%h, required 1 00000002 2",
                             c, if4.m_axis_tvalid, if4.m_axis_tdata, if4.m_axis_tuser);
                else passed++;
            end
            if (c == 18) begin
                total++;
                if (if4.m_axis_tvalid !== 1'b1 || if4.m_axis_tdata !== 32'h0000_0303 || if4.m_axis_tlast !== 1'b1)
                    $display("FAIL bp_last_hold: got valid=%b data=%h last=%b, required 1 00000303 1",
                             if4.m_axis_tvalid, if4.m_axis_tdata, if4.m_axis_tlast);
                else passed++;
            end
            tick;
        end
        if4.m_axis_tready = 1'b1;
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL bp_idle: got %b, required 0", if4.m_axis_tvalid); else passed++;
        total++; if (beats4 - b0 !== 16) $display("FAIL bp_beats: got %0d, required 16", beats4 - b0); else passed++;
    endtask

    task automatic test_back_to_back;
        int b0;
        tick;
        load4(1);
        if4.s_axis_tvalid = 1'b1;
        b0 = beats4;
        @(negedge clk);
        tick;
        load4(2);
        for (int c = 0; c < 32; c++) begin
            if (c == 16) if4.s_axis_tvalid = 1'b0;
            @(negedge clk);
            total++;
            if (if4.s_axis_tready !== 1'((c == 15) || (c == 31)) || if4.m_axis_tvalid !== 1'b1)
                $display("FAIL b2b_c%0d: got sready=%b valid=%b, required sready=%b valid=1",
                         c, if4.s_axis_tready, if4.m_axis_tvalid, 1'((c == 15) || (c == 31)));
            else passed++;
            tick;
        end
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL b2b_idle: got %b, required 0", if4.m_axis_tvalid); else passed++;
        total++; if (beats4 - b0 !== 32) $display("FAIL b2b_beats: got %0d, required 32", beats4 - b0); else passed++;
    endtask

    task automatic test_input_while_busy;
        int b0;
        tick;
        load4(0);
        if4.s_axis_tvalid = 1'b1;
        b0 = beats4;
        @(negedge clk);
        tick;
        if4.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (c == 4) begin
                load4(3);
                if4.s_axis_tvalid = 1'b1;
            end
            if (c == 16) if4.s_axis_tvalid = 1'b0;
            @(negedge clk);
            if (c >= 4) begin
                total++;
                if (if4.s_axis_tready !== 1'((c == 15) || (c == 31)))
                    $display("FAIL busy_sready_c%0d: got %b, required %b",
                             c, if4.s_axis_tready, 1'((c == 15) || (c == 31)));
                else passed++;
            end
            tick;
        end
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL busy_idle: got %b, required 0", if4.m_axis_tvalid); else passed++;
        total++; if (beats4 - b0 !== 32) $display("FAIL busy_beats: got %0d, required 32", beats4 - b0); else passed++;
    endtask

    task automatic test_reset_mid;
        int b0;
        tick;
        load4(0);
        if4.s_axis_tvalid = 1'b1;
        b0 = beats4;
        @(negedge clk);
        tick;
        if4.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tick;
        end
        reset = 1'b1;
        q4.delete();
        @(negedge clk);
        tick;
        reset = 1'b0;
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b, required 0", if4.m_axis_tvalid); else passed++;
        total++; if (if4.s_axis_tready !== 1'b1) $display("FAIL mid_sready: got %b, required 1", if4.s_axis_tready); else passed++;
        total++; if (if4.m_axis_tuser !== 4'h0) $display("FAIL mid_tuser: got %h, required 0", if4.m_axis_tuser); else passed++;
        total++; if (beats4 - b0 !== 6) $display("FAIL mid_beats: got %0d, required 6", beats4 - b0); else passed++;
        tick;
        load4(2);
        if4.s_axis_tvalid = 1'b1;
        @(negedge clk);
        tick;
        if4.s_axis_tvalid = 1'b0;
        @(negedge clk);
        total++;
        if (if4.m_axis_tvalid !== 1'b1 || if4.m_axis_tdata !== 32'h0000_1000 || if4.m_axis_tuser !== 4'h0)
            $display("FAIL mid_restart: got valid=%b data=%h user=%h, required 1 00001000 0",
                     if4.m_axis_tvalid, if4.m_axis_tdata, if4.m_axis_tuser);
        else passed++;
        for (int c = 1; c < 16; c++) @(negedge clk);
        @(negedge clk);
        total++; if (if4.m_axis_tvalid !== 1'b0) $display("FAIL mid_idle: got %b, required 0", if4.m_axis_tvalid); else passed++;
    endtask

    task automatic test_size2;
        logic [63:0] f;
        logic [15:0] v;
        int b0;
        tick;
        f = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                v = 16'(16'h00A0 + 2 * i + j);
                f = f | (64'(v) << ((2 * i + j) * 16));
                q2.push_back('{d: 32'(v), u: 4'(2 * i + j), l: (i == 1 && j == 1)});
            end
        end
        if2.s_axis_tdata = f;
        if2.s_axis_tvalid = 1'b1;
        b0 = beats2;
        @(negedge clk);
        total++; if (if2.s_axis_tready !== 1'b1) $display("FAIL s2_sready: got %b, required 1", if2.s_axis_tready); else passed++;
        tick;
        if2.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (if2.m_axis_tvalid !== 1'b1) $display("FAIL s2_valid_c%0d: got %b, required 1", c, if2.m_axis_tvalid);
            else passed++;
        end
        @(negedge clk);
        total++; if (if2.m_axis_tvalid !== 1'b0) $display("FAIL s2_idle: got %b, required 0", if2.m_axis_tvalid); else passed++;
        total++; if (beats2 - b0 !== 4) $display("FAIL s2_beats: got %0d, required 4", beats2 - b0); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        if4.s_axis_tdata  = '0;
        if4.s_axis_tvalid = 1'b0;
        if4.m_axis_tready = 1'b1;
        if2.s_axis_tdata  = '0;
        if2.s_axis_tvalid = 1'b0;
        if2.m_axis_tready = 1'b1;

        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_input_while_busy;
        test_reset_mid;
        test_size2;

        total++; if (q4.size() != 0) $display("FAIL q4_drained: got %0d left, required 0", q4.size()); else passed++;
        total++; if (q2.size() != 0) $display("FAIL q2_drained: got %0d left, required 0", q2.size()); else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
